morse_tx_gen: RTL and testbench
===============================

Name: morse_tx_gen

Overview:
Parametrised Morse transmitter, successor to the fixed 8-letter / 11-bit encoder. It holds a runtime-writable symbol table of 2**SEL_W entries, each a pattern of up to PAT_W bits with a per-entry length. It serialises one selected entry MSB-first at one bit per CLK_DIV clocks and reports progress with a start/busy/done handshake plus abort. It sits between the switch/key front end and the LED/buzzer driver.

Parameters:
CLK_DIV, 250, clocks per Morse bit (>=2)
DIV_W, 8, divider counter width; must satisfy 2**DIV_W >= CLK_DIV
PAT_W, 16, maximum pattern bits per table entry
LEN_W, 5, width of the length field; must satisfy 2**LEN_W > PAT_W
SEL_W, 3, table address width (table depth = 2**SEL_W)

Ports:
clk  in  1  system clock
Resetn  in  1  asynchronous, active-low reset
start  in  1  request transmission of entry sel; sampled only when busy=0
sel  in  SEL_W  table entry to transmit
abort  in  1  synchronous cancel of the current transmission
wr_en  in  1  table write strobe
wr_addr  in  SEL_W  table write address
wr_pat  in  PAT_W  pattern to write, MSB transmitted first
wr_len  in  LEN_W  number of bits to transmit for this entry
dot_dash  out  1  serial Morse output
bit_tick  out  1  one-cycle pulse on the last clock of each transmitted bit
busy  out  1  high while transmitting
done  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset: all table entries cleared (pattern 0, length 0); FSM goes to IDLE; dot_dash=0, bit_tick=0, busy=0, done=0; divider=0; bit counter=0.
- Table write: on a clk edge with wr_en=1, entry[wr_addr] <= {wr_pat, wr_len}. Writes are allowed in any state. The in-flight message is unaffected because it is latched at start.
- FSM has states IDLE and SEND. done is a registered pulse, not a separate state.
- IDLE:
  - On start=1 and abort=0, latch shreg<=entry[sel].pat and cnt<=min(entry[sel].len, PAT_W).
  - If cnt would be 0: stay in IDLE and pulse done on the next cycle. busy stays 0.
  - Otherwise go to SEND and load divider<=CLK_DIV-1.
  - busy=1 and dot_dash=shreg[PAT_W-1] from the next cycle. Start-to-first-bit latency is 1 clock.
- Same-cycle write and start to the same address: start uses the pre-write contents.
- SEND:
  - While divider!=0, decrement the divider.
  - When divider==0, assert bit_tick, shift shreg left (zero fill), decrement cnt, and reload the divider to CLK_DIV-1.
  - If cnt was 1 at that tick, go to IDLE: next cycle busy=0, dot_dash=0, done=1 for one cycle.
  - Each bit is held for exactly CLK_DIV clocks. Total busy duration = len*CLK_DIV clocks.
- start while busy=1 is ignored (not queued).
- abort=1 has priority over start and the divider:
  - In SEND, abort forces IDLE next cycle with dot_dash=0, busy=0, no done, and no bit_tick in that cycle.
  - In IDLE, abort is a no-op and blocks start that cycle.
- A Resetn assertion mid-transmission takes effect immediately (async): all outputs drop to 0 and the table is cleared.
- dot_dash is driven directly from the shift-register MSB and is gated to 0 in IDLE.

Optional Feature:
MORSE_REPEAT_EN
- Defined: adds input repeat (1 bit) and parameter GAP_BITS (default 7), plus a GAP state.
- On normal completion with repeat=1: pulse done, go to GAP with dot_dash=0 and busy=1 for GAP_BITS*CLK_DIV clocks (bit_tick still pulses per bit).
- After the gap, re-latch entry[sel] (the current sel and table contents) and re-enter SEND.
- If repeat=0 at the end of a gap, or abort at any time, go to IDLE.
- Not defined: no repeat port, no GAP state; behaviour exactly as above.

Test Plan:
1. CLK_DIV=4; write entry 0 = pat 16'b1011_1000_0000_0000, len 5; pulse start with sel=0 -> dot_dash outputs 1,0,1,1,1, each held 4 clocks; 5 bit_tick pulses; busy high for 20 clocks; done 1 cycle after the last tick; dot_dash=0 afterwards.
2. Entry 3 with len 0; start with sel=3 -> busy stays 0, done pulses 1 cycle after start, no bit_tick.
3. Write len 20 (> PAT_W=16) with an all-ones pattern -> exactly 16 ones transmitted (64 clocks at CLK_DIV=4), then done.
4. Start entry 0 (as in test 1); assert abort during bit 3 -> next cycle busy=0, dot_dash=0, no done; a new start is accepted the following cycle.
5. During SEND, pulse start with another sel and rewrite entry 0 -> output unchanged from the original pattern. Separately, write and start the same address in one cycle -> the old pattern is transmitted.
6. Assert Resetn low mid-bit -> dot_dash, busy, bit_tick, done go to 0 immediately; after release, start on entry 0 -> done after 0 bits, since the table was cleared.

Source files
------------

// File: rtl/morse_tx_gen.sv
// Morse transmitter: writable symbol table, MSB-first serialiser with start/busy/done/abort.
// Optional MORSE_REPEAT_EN adds repeat_en input, GAP_BITS parameter and a GAP state.
module morse_tx_gen #(
    parameter int unsigned CLK_DIV  = 250,
    parameter int unsigned DIV_W    = 8,
    parameter int unsigned PAT_W    = 16,
    parameter int unsigned LEN_W    = 5,
    parameter int unsigned SEL_W    = 3
`ifdef MORSE_REPEAT_EN
    ,
    parameter int unsigned GAP_BITS = 7
`endif
) (
    input  logic             clk,
    input  logic             Resetn,
    input  logic             start,
    input  logic [SEL_W-1:0] sel,
    input  logic             abort,
`ifdef MORSE_REPEAT_EN
    input  logic             repeat_en,
`endif
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_addr,
    input  logic [PAT_W-1:0] wr_pat,
    input  logic [LEN_W-1:0] wr_len,
    output logic             dot_dash,
    output logic             bit_tick,
    output logic             busy,
    output logic             done
);

    localparam int unsigned DEPTH = 1 << SEL_W;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [LEN_W-1:0] PAT_MAX = LEN_W'(PAT_W);

`ifdef MORSE_REPEAT_EN
    localparam int unsigned GAP_W = $clog2(GAP_BITS + 1);
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
`else
    typedef enum logic {IDLE, SEND} state_t;
`endif

    state_t           state, state_n;
    logic [PAT_W-1:0] shreg, shreg_n;
    logic [LEN_W-1:0] cnt, cnt_n;
    logic [DIV_W-1:0] div, div_n;
    logic             done_r, done_n;
    logic             tick;
    logic [LEN_W-1:0] sel_len;

    logic [PAT_W-1:0] tbl_pat [DEPTH];
    logic [LEN_W-1:0] tbl_len [DEPTH];

`ifdef MORSE_REPEAT_EN
    logic [GAP_W-1:0] gap_cnt, gap_n;
`endif

    // Start reads the table before any same-cycle write lands.
    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tbl_pat[i] <= '0;
                tbl_len[i] <= '0;
            end
        end else if (wr_en) begin
            tbl_pat[wr_addr] <= wr_pat;
            tbl_len[wr_addr] <= wr_len;
        end
    end

    assign sel_len = (tbl_len[sel] > PAT_MAX) ? PAT_MAX : tbl_len[sel];

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n   = cnt;
        div_n   = div;
        done_n  = 1'b0;
        tick    = 1'b0;
`ifdef MORSE_REPEAT_EN
        gap_n   = gap_cnt;
`endif
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    shreg_n = tbl_pat[sel];
                    cnt_n   = sel_len;
                    if (sel_len == '0) begin
                        done_n = 1'b1;
                    end else begin
                        state_n = SEND;
                        div_n   = DIV_MAX;
                    end
                end
            end
            SEND: begin
                if (abort) begin
                    state_n = IDLE;
                    div_n   = '0;
                    cnt_n   = '0;
                end else if (div != '0) begin
                    div_n = div - DIV_W'(1);
                end else begin
                    tick    = 1'b1;
                    shreg_n = shreg << 1;
                    cnt_n   = cnt - LEN_W'(1);
                    div_n   = DIV_MAX;
                    if (cnt == LEN_W'(1)) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                        div_n   = '0;
`ifdef MORSE_REPEAT_EN
                        if (repeat_en) begin
                            state_n = GAP;
                            div_n   = DIV_MAX;
                            gap_n   = GAP_W'(GAP_BITS);
                        end
`endif
                    end
                end
            end
`ifdef MORSE_REPEAT_EN
            GAP: begin
                if (abort) begin
                    state_n = IDLE;
                    div_n   = '0;
                end else if (div != '0) begin
                    div_n = div - DIV_W'(1);
                end else begin
                    tick  = 1'b1;
                    gap_n = gap_cnt - GAP_W'(1);
                    div_n = DIV_MAX;
                    if (gap_cnt == GAP_W'(1)) begin
                        state_n = IDLE;
                        div_n   = '0;
                        // Re-latch from the live sel/table so edits take effect on the next repeat.
                        if (repeat_en) begin
                            shreg_n = tbl_pat[sel];
                            cnt_n   = sel_len;
                            if (sel_len == '0) begin
                                done_n = 1'b1;
                            end else begin
                                state_n = SEND;
                                div_n   = DIV_MAX;
                            end
                        end
                    end
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            div    <= '0;
            done_r <= 1'b0;
`ifdef MORSE_REPEAT_EN
            gap_cnt <= '0;
`endif
        end else begin
            state  <= state_n;
            shreg  <= shreg_n;
            cnt    <= cnt_n;
            div    <= div_n;
            done_r <= done_n;
`ifdef MORSE_REPEAT_EN
            gap_cnt <= gap_n;
`endif
        end
    end

    assign dot_dash = (state == SEND) && shreg[PAT_W-1];
    assign bit_tick = tick;
    assign busy     = (state != IDLE);
    assign done     = done_r;

endmodule

// File: tb/tb_morse_tx_gen.sv
// Scoreboard bench for morse_tx_gen at CLK_DIV=4: expected bits queued at start, popped on bit_tick.
module tb_morse_tx_gen;

    logic        clk = 1'b0;
    logic        Resetn = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  sel = '0;
    logic [2:0]  wr_addr = '0;
    logic [15:0] wr_pat = '0;
    logic [4:0]  wr_len = '0;
    logic        dot_dash, bit_tick, busy, done;
`ifdef MORSE_REPEAT_EN
    logic        repeat_en = 1'b0;
`endif

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_tick = 0;
    bit first_tick = 1'b1;
    bit exp_q[$];

    morse_tx_gen #(
        .CLK_DIV(4),
        .DIV_W  (3),
        .PAT_W  (16),
        .LEN_W  (5),
        .SEL_W  (3)
    ) dut (
        .clk      (clk),
        .Resetn   (Resetn),
        .start    (start),
        .sel      (sel),
        .abort    (abort),
`ifdef MORSE_REPEAT_EN
        .repeat_en(repeat_en),
`endif
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_pat   (wr_pat),
        .wr_len   (wr_len),
        .dot_dash (dot_dash),
        .bit_tick (bit_tick),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Every busy cycle must show the head bit; a tick retires it and must land 4 clocks after the last.
    always @(negedge clk) begin
        if (busy && exp_q.size() > 0)
            check("dot_dash_hold", dot_dash, exp_q[0]);
        if (bit_tick) begin
            if (exp_q.size() == 0)
                check("tick_unexpected", 1, 0);
            else
                check("dot_dash_bit", dot_dash, exp_q.pop_front());
            if (!first_tick)
                check("bit_period", cyc - last_tick, 4);
            first_tick = 1'b0;
            last_tick  = cyc;
        end
    end

    task automatic write_entry(input logic [2:0] a, input logic [15:0] p, input logic [4:0] l);
        wr_en = 1'b1; wr_addr = a; wr_pat = p; wr_len = l;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic start_tx(input logic [2:0] s, input logic [15:0] p, input int len);
        int n;
        n = (len > 16) ? 16 : len;
        for (int i = 0; i < n; i++) exp_q.push_back(p[15-i]);
        first_tick = 1'b1;
        sel = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic finish_msg(input int exp_busy);
        int n;
        n = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        check("busy_cycles", n, exp_busy);
        check("done_pulse", done, 1);
        check("dot_dash_idle", dot_dash, 0);
        check("queue_drained", exp_q.size(), 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int t;
        repeat (2) @(negedge clk);
        check("rst_dot_dash", dot_dash, 0);
        check("rst_bit_tick", bit_tick, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        Resetn = 1'b1;
        @(posedge clk); #1;

        // Basic 5-bit entry
        write_entry(3'd0, 16'hB800, 5'd5);
        start_tx(3'd0, 16'hB800, 5);
        finish_msg(20);

        // Zero length: done without busy
        write_entry(3'd3, 16'hFFFF, 5'd0);
        start_tx(3'd3, 16'hFFFF, 0);
        finish_msg(0);

        // Length beyond PAT_W clips to 16 bits
        write_entry(3'd4, 16'hFFFF, 5'd20);
        start_tx(3'd4, 16'hFFFF, 20);
        finish_msg(64);

        // Abort during bit 3, then immediate restart
        start_tx(3'd0, 16'hB800, 5);
        t = 0;
        for (int k = 0; k < 100 && t < 2; k++) begin
            @(negedge clk);
            if (bit_tick) t++;
        end
        check("abort_ticks_seen", t, 2);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_dot_dash", dot_dash, 0);
        check("abort_no_done", done, 0);
        exp_q.delete();
        start_tx(3'd0, 16'hB800, 5);
        finish_msg(20);

        // Start and table rewrite while busy do not disturb the message
        write_entry(3'd1, 16'h5555, 5'd8);
        start_tx(3'd0, 16'hB800, 5);
        repeat (5) @(posedge clk);
        #1;
        sel = 3'd1; start = 1'b1;
        wr_en = 1'b1; wr_addr = 3'd0; wr_pat = 16'h0000; wr_len = 5'd3;
        @(posedge clk); #1;
        start = 1'b0; wr_en = 1'b0;
        finish_msg(14);
        @(negedge clk);
        check("busy_start_ignored", busy, 0);
        @(posedge clk); #1;

        // Same-cycle write and start: old contents transmitted
        write_entry(3'd2, 16'hA000, 5'd4);
        wr_en = 1'b1; wr_addr = 3'd2; wr_pat = 16'hFFFF; wr_len = 5'd8;
        start_tx(3'd2, 16'hA000, 4);
        wr_en = 1'b0;
        finish_msg(16);

        // Async reset mid-bit clears outputs and table
        start_tx(3'd2, 16'hFFFF, 8);
        repeat (6) @(posedge clk);
        #2;
        Resetn = 1'b0;
        #1;
        check("arst_dot_dash", dot_dash, 0);
        check("arst_bit_tick", bit_tick, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        exp_q.delete();
        @(negedge clk);
        Resetn = 1'b1;
        @(posedge clk); #1;
        start_tx(3'd0, 16'hB800, 0);
        finish_msg(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
